// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial full-adder FSM and its downstream collector.
// Contents:
//   DEFAULT_WIDTH - default operand width (serial bits per frame)
//   state_t       - collector/adder state encoding (IDLE, COLLECT, HOLD)
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_COLLECT_ENC = 2'd1;
    localparam logic [1:0] ST_HOLD_ENC    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE_ENC,
        COLLECT = ST_COLLECT_ENC,
        HOLD    = ST_HOLD_ENC
    } state_t;

endpackage

// File: rtl/serial_sum_collector.sv
// serial_sum_collector: assembles the LSB-first serial sum stream of the serial
// adder into a parallel WIDTH+1-bit result ({final carry, sum}) and offers it
// to the parallel consumer with a valid/ready handshake.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-low reset
//   start        - frame-start pulse (same pulse that launches the adder)
//   bit_valid    - sum_bit/carry_bit are valid this cycle
//   sum_bit      - serial sum bit, LSB first
//   carry_bit    - adder carry after the current bit
//   result       - {final carry, sum[WIDTH-1:0]}, stable while result_valid
//   result_valid - result available
//   result_ready - consumer accepts result
//   busy         - high while collecting a frame
//   overrun      - sticky error: start or bit arrived while result was pending
//
// Optional feature (macro SERIAL_SUM_CHECK_EN):
//   exp_a, exp_b - expected operands, captured on an accepted start
//   check_err    - registered with result_valid; 1 when result != exp_a+exp_b
module serial_sum_collector
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             sum_bit,
    input  logic             carry_bit,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    input  logic             result_ready,
`ifdef SERIAL_SUM_CHECK_EN
    input  logic [WIDTH-1:0] exp_a,
    input  logic [WIDTH-1:0] exp_b,
    output logic             check_err,
`endif
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RES_W = WIDTH + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;

    logic [RES_W-1:0] frame_c;
    logic             last_bit_c;
    logic             start_acc_c;
    logic             done_c;
    logic             accept_c;

    // Final word: the last strobe supplies both the top sum bit and the carry.
    assign frame_c     = {carry_bit, sum_bit, shreg[WIDTH-1:1]};
    assign last_bit_c  = (cnt == CNT_W'(WIDTH - 1));
    assign start_acc_c = start && ((state == IDLE) || (state == COLLECT) ||
                                   ((state == HOLD) && result_ready));
    assign done_c      = (state == COLLECT) && bit_valid && !start && last_bit_c;
    assign accept_c    = (state == HOLD) && result_ready;

    // Main FSM with counter, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        cnt   <= '0;
                        shreg <= '0;
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    // A start restarts the frame and drops any same-cycle bit.
                    if (start) begin
                        cnt   <= '0;
                        shreg <= '0;
                    end else if (bit_valid) begin
                        if (last_bit_c) begin
                            result       <= frame_c;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            state        <= HOLD;
                        end else begin
                            shreg <= {sum_bit, shreg[WIDTH-1:1]};
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bit_valid || (start && !result_ready)) begin
                        overrun <= 1'b1;
                    end
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (start) begin
                            state <= COLLECT;
                            cnt   <= '0;
                            shreg <= '0;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_SUM_CHECK_EN
    logic [RES_W-1:0] exp_sum;

    // Expected sum is latched per frame and compared as the result is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_sum   <= '0;
            check_err <= 1'b0;
        end else begin
            if (start_acc_c) begin
                exp_sum <= RES_W'(exp_a) + RES_W'(exp_b);
            end
            if (done_c) begin
                check_err <= (frame_c != exp_sum);
            end else if (accept_c) begin
                check_err <= 1'b0;
            end
        end
    end
`else
    logic unused_c;
    assign unused_c = start_acc_c ^ done_c ^ accept_c;
`endif

endmodule
